emin_scheduler: RTL

EMIN_SCHEDULER -- requirements
Module: emin_scheduler

---
 rtl/emin_scheduler_if.sv | 28 ++
 rtl/emin_scheduler.sv | 130 +++++++++++++
 2 files changed

// File: rtl/emin_scheduler_if.sv
// Engine handshake and triangular E-buffer write port of the Emin scheduler.
// master = scheduler side, slave = engine/buffer side.
interface emin_scheduler_if #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160
);
  localparam int IW = $clog2(I);
  localparam int AW = $clog2(I*(I+1)/2);

  logic [IW-1:0]        emin_i_out;
  logic                 emin_valid_out;
  logic [IW-1:0]        emin_j_in;
  logic [BIT_WIDTH-1:0] emin_data_in;
  logic                 emin_valid_in;
  logic                 wr_en_out;
  logic [AW-1:0]        wr_addr_out;
  logic [BIT_WIDTH-1:0] wr_data_out;

  modport master (
    output emin_i_out, emin_valid_out, wr_en_out, wr_addr_out, wr_data_out,
    input  emin_j_in, emin_data_in, emin_valid_in
  );

  modport slave (
    input  emin_i_out, emin_valid_out, wr_en_out, wr_addr_out, wr_data_out,
    output emin_j_in, emin_data_in, emin_valid_in
  );
endinterface

// File: rtl/emin_scheduler.sv
// Sweeps rows i=0..I-1 through the Emin engine, collects j=0..i in order and
// writes each result to the packed lower-triangular buffer at i*(i+1)/2 + j.
module emin_scheduler #(
  parameter int BIT_WIDTH = 32,
  parameter int I         = 160,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  emin_scheduler_if.master  bus,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);
  localparam int IW = $clog2(I);
  localparam int AW = $clog2(I*(I+1)/2);
  localparam int WW = $clog2(TIMEOUT+1);
  localparam logic [IW-1:0] I_LAST  = IW'(I-1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT-1);

  typedef enum logic [2:0] {IDLE, ISSUE, COLLECT, ADVANCE, FINISH} state_e;

  state_e               state_q;
  logic [IW-1:0]        i_q;
  logic [IW-1:0]        exp_j_q;
  logic [AW-1:0]        base_q;
  logic [WW-1:0]        wd_q;
  logic                 issue_q;
  logic                 wr_en_q;
  logic [AW-1:0]        wr_addr_q;
  logic [BIT_WIDTH-1:0] wr_data_q;
  logic                 busy_q, done_q, err_q;

  logic [AW-1:0]        base_d;
  logic [AW-1:0]        wr_addr_d;
  logic                 j_match;

  // Row base i*(i+1)/2 is accumulated: base(i+1) = base(i) + i + 1.
  assign base_d    = base_q + AW'(i_q) + AW'(1);
  assign wr_addr_d = base_q + AW'(exp_j_q);
  assign j_match   = (bus.emin_j_in == exp_j_q);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      i_q       <= '0;
      exp_j_q   <= '0;
      base_q    <= '0;
      wd_q      <= '0;
      issue_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      issue_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: if (start_in) begin
          i_q     <= '0;
          base_q  <= '0;
          exp_j_q <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b1;
          issue_q <= 1'b1;
          state_q <= ISSUE;
        end
        ISSUE: begin
          wd_q    <= '0;
          state_q <= COLLECT;
        end
        COLLECT: begin
          if (bus.emin_valid_in) begin
            wd_q <= '0;
            if (j_match) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= wr_addr_d;
              wr_data_q <= bus.emin_data_in;
              exp_j_q   <= exp_j_q + 1'b1;
              if (exp_j_q == i_q) state_q <= ADVANCE;
            end else begin
              // Out-of-order result: abort the sweep, nothing is written.
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        // ADVANCE is the extra idle cycle that lets the engine settle before
        // the next issue.
        ADVANCE: begin
          if (i_q == I_LAST) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else begin
            base_q  <= base_d;
            i_q     <= i_q + 1'b1;
            exp_j_q <= '0;
            issue_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.emin_i_out     = i_q;
  assign bus.emin_valid_out = issue_q;
  assign bus.wr_en_out      = wr_en_q;
  assign bus.wr_addr_out    = wr_addr_q;
  assign bus.wr_data_out    = wr_data_q;
  assign busy_out           = busy_q;
  assign done_out           = done_q;
  assign err_out            = err_q;
endmodule
